// File: rtl/control_sequencer_if.sv
// Bundle between the control sequencer and its surroundings: the instruction
// handshake from the fetch side plus the control lines into the datapath.
interface control_sequencer_if #(
   parameter int nBit = 16
);
   logic            instr_valid;
   logic [15:0]     instr;
   logic            instr_ready;
   logic            zero_flag;
   logic [2:0]      FS;
   logic            A_thru;
   logic            B_thru;
   logic [3:0]      a_sel;
   logic [3:0]      b_sel;
   logic            imm_sel;
   logic [nBit-1:0] imm_out;
   logic            wr_en;
   logic [3:0]      wr_addr;
   logic            pc_inc;
   logic            pc_load;
   logic [7:0]      pc_offset;
   logic            halted;
   logic            illegal;

   // Instruction source / datapath side
   modport master (
      output instr_valid, instr, zero_flag,
      input  instr_ready, FS, A_thru, B_thru, a_sel, b_sel, imm_sel, imm_out,
             wr_en, wr_addr, pc_inc, pc_load, pc_offset, halted, illegal
   );

   // Sequencer side
   modport slave (
      input  instr_valid, instr, zero_flag,
      output instr_ready, FS, A_thru, B_thru, a_sel, b_sel, imm_sel, imm_out,
             wr_en, wr_addr, pc_inc, pc_load, pc_offset, halted, illegal
   );
endinterface

// File: rtl/control_sequencer.sv
// Four-cycle control sequencer: accepts a 16-bit instruction, decodes it and
// drives the functional unit, register-file writeback and PC controls.
// Every output except instr_ready depends only on the state and the IR.
module control_sequencer #(
   parameter int nBit = 16
) (
   input  logic                clk,
   input  logic                rst,
   control_sequencer_if.slave  bus
);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXECUTE, S_COMPLETE, S_HALT
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] ir_q, ir_d;
   logic        z_q, z_d;
   logic        illegal_q, illegal_d;
   // Holds instr_ready low until the first edge after reset releases.
   logic        ready_en_q, ready_en_d;

   logic [3:0]  op, rd, ra, rb;
   logic [7:0]  imm8;
   logic        is_branch, is_jump_class, taken;

   assign op   = ir_q[15:12];
   assign rd   = ir_q[11:8];
   assign ra   = ir_q[7:4];
   assign rb   = ir_q[3:0];
   assign imm8 = ir_q[7:0];

   assign is_branch     = (op == 4'hA) || (op == 4'hB);
   assign is_jump_class = is_branch || (op == 4'hC);
   assign taken         = (op == 4'hC) || ((op == 4'hA) && z_q) || ((op == 4'hB) && !z_q);

   logic            instr_ready_c;
   logic [2:0]      fs_c;
   logic            a_thru_c, b_thru_c, imm_sel_c;
   logic [3:0]      a_sel_c, b_sel_c;
   logic [nBit-1:0] imm_out_c;
   logic            wr_en_c;
   logic [3:0]      wr_addr_c;
   logic            pc_inc_c, pc_load_c;
   logic [7:0]      pc_offset_c;
   logic            halted_c;

   // State register, IR, sampled zero flag and sticky illegal flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_FETCH;
         ir_q       <= '0;
         z_q        <= 1'b0;
         illegal_q  <= 1'b0;
         ready_en_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ir_q       <= ir_d;
         z_q        <= z_d;
         illegal_q  <= illegal_d;
         ready_en_q <= ready_en_d;
      end
   end

   // Next-state logic and control decode from state and IR
   always_comb begin
      state_d       = state_q;
      ir_d          = ir_q;
      z_d           = z_q;
      illegal_d     = illegal_q;
      ready_en_d    = 1'b1;
      instr_ready_c = 1'b0;
      fs_c          = 3'd0;
      a_thru_c      = 1'b0;
      b_thru_c      = 1'b0;
      imm_sel_c     = 1'b0;
      a_sel_c       = 4'd0;
      b_sel_c       = 4'd0;
      imm_out_c     = '0;
      wr_en_c       = 1'b0;
      wr_addr_c     = 4'd0;
      pc_inc_c      = 1'b0;
      pc_load_c     = 1'b0;
      pc_offset_c   = 8'd0;
      halted_c      = 1'b0;

      case (state_q)
         S_FETCH: begin
            instr_ready_c = ready_en_q;
            if (bus.instr_valid && ready_en_q) begin
               ir_d    = bus.instr;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            a_sel_c     = is_branch ? rd : ra;
            b_sel_c     = rb;
            pc_offset_c = is_jump_class ? imm8 : 8'd0;
            state_d     = S_EXECUTE;
         end
         S_EXECUTE, S_COMPLETE: begin
            // Functional-unit controls stay held through COMPLETE.
            a_sel_c     = is_branch ? rd : ra;
            b_sel_c     = rb;
            pc_offset_c = is_jump_class ? imm8 : 8'd0;
            if (!op[3]) begin
               fs_c = op[2:0];
            end else if (op == 4'h8) begin
               a_thru_c = 1'b1;
            end else if (op == 4'h9) begin
               b_thru_c  = 1'b1;
               imm_sel_c = 1'b1;
               imm_out_c = {{(nBit-8){1'b0}}, imm8};
            end else if (is_branch) begin
               a_thru_c = 1'b1;
            end

            if (state_q == S_EXECUTE) begin
               z_d     = bus.zero_flag;
               state_d = S_COMPLETE;
            end else begin
               state_d = S_FETCH;
               if (op <= 4'h9) begin
                  wr_en_c   = 1'b1;
                  wr_addr_c = rd;
                  pc_inc_c  = 1'b1;
               end else if (op == 4'hF) begin
                  state_d = S_HALT;
               end else begin
                  if ((op == 4'hD) || (op == 4'hE)) begin
                     illegal_d = 1'b1;
                  end
                  pc_load_c = taken;
                  pc_inc_c  = !taken;
               end
            end
         end
         S_HALT: begin
            halted_c = 1'b1;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   assign bus.instr_ready = instr_ready_c;
   assign bus.FS          = fs_c;
   assign bus.A_thru      = a_thru_c;
   assign bus.B_thru      = b_thru_c;
   assign bus.a_sel       = a_sel_c;
   assign bus.b_sel       = b_sel_c;
   assign bus.imm_sel     = imm_sel_c;
   assign bus.imm_out     = imm_out_c;
   assign bus.wr_en       = wr_en_c;
   assign bus.wr_addr     = wr_addr_c;
   assign bus.pc_inc      = pc_inc_c;
   assign bus.pc_load     = pc_load_c;
   assign bus.pc_offset   = pc_offset_c;
   assign bus.halted      = halted_c;
   assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed cases from the
// instruction set plus randomized instructions against a behavioural model.
module tb_control_sequencer;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_bad;
   bit   ill_model;

   control_sequencer_if #(.nBit(16)) bus ();

   control_sequencer #(.nBit(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] all_ctl();
      return {bus.instr_ready, bus.FS, bus.A_thru, bus.B_thru, bus.a_sel, bus.b_sel,
              bus.imm_sel, bus.wr_en, bus.wr_addr, bus.pc_inc, bus.pc_load,
              bus.halted, bus.illegal};
   endfunction

   // Issue one instruction and check every phase against the model.
   task automatic run_instr(input logic [15:0] iw, input logic zf);
      int unsigned op, rd, ra, rb, imm;
      bit          branch, taken, writes;
      int          waited;
      op  = int'(iw[15:12]);
      rd  = int'(iw[11:8]);
      ra  = int'(iw[7:4]);
      rb  = int'(iw[3:0]);
      imm = int'(iw[7:0]);
      branch = (op == 10) || (op == 11);
      writes = (op <= 9);
      taken  = (op == 12) || (op == 10 && zf) || (op == 11 && !zf);

      @(negedge clk);
      bus.instr_valid = 1'b1;
      bus.instr       = iw;
      waited = 0;
      while (!bus.instr_ready && waited < 8) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.instr_ready) begin
         chk("ready_timeout", 32'(bus.instr_ready), 32'd1);
         bus.instr_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      // Garbage on the handshake outside FETCH must be ignored.
      bus.instr_valid = 1'($urandom_range(0, 1));
      bus.instr       = 16'($urandom);

      @(negedge clk);  // DECODE
      chk("dec_ready", 32'(bus.instr_ready), 32'd0);
      chk("dec_a_sel", 32'(bus.a_sel), branch ? rd : ra);
      chk("dec_b_sel", 32'(bus.b_sel), rb);

      @(negedge clk);  // EXECUTE
      chk("ex_fs", 32'(bus.FS), (op < 8) ? op : 32'd0);
      chk("ex_a_thru", 32'(bus.A_thru), 32'(op == 8 || branch));
      chk("ex_b_thru", 32'(bus.B_thru), 32'(op == 9));
      chk("ex_imm_sel", 32'(bus.imm_sel), 32'(op == 9));
      chk("ex_imm_out", 32'(bus.imm_out), (op == 9) ? imm : 32'd0);
      chk("ex_pulses", 32'({bus.wr_en, bus.pc_inc, bus.pc_load}), 32'd0);
      bus.zero_flag = zf;
      @(posedge clk);
      #1;
      bus.zero_flag = !zf;  // late change must not matter

      @(negedge clk);  // COMPLETE
      chk("cp_fs", 32'(bus.FS), (op < 8) ? op : 32'd0);
      chk("cp_imm_out", 32'(bus.imm_out), (op == 9) ? imm : 32'd0);
      chk("cp_wr_en", 32'(bus.wr_en), 32'(writes));
      chk("cp_wr_addr", 32'(bus.wr_addr), writes ? rd : 32'd0);
      chk("cp_pc_load", 32'(bus.pc_load), 32'(taken));
      chk("cp_pc_inc", 32'(bus.pc_inc), 32'(op != 15 && !taken));
      chk("cp_pc_offset", 32'(bus.pc_offset), (op >= 10 && op <= 12) ? imm : 32'd0);
      if (op == 13 || op == 14) ill_model = 1'b1;
      bus.instr_valid = 1'b0;

      @(negedge clk);  // FETCH or HALT
      chk("post_ready", 32'(bus.instr_ready), 32'(op != 15));
      chk("post_halted", 32'(bus.halted), 32'(op == 15));
      chk("post_illegal", 32'(bus.illegal), 32'(ill_model));
      $display("instr %04h zf=%0d wr=%0d pc_inc=%0d pc_load=%0d ill=%0d",
               iw, zf, writes, (op != 15 && !taken), taken, ill_model);
   endtask

   // Abandon an ALU op by asserting reset asynchronously during EXECUTE.
   task automatic reset_mid_execute();
      logic [15:0] iw;
      iw = {1'b0, 3'($urandom_range(0, 7)), 12'($urandom)};
      @(negedge clk);
      bus.instr_valid = 1'b1;
      bus.instr       = iw;
      @(posedge clk);
      #1;
      bus.instr_valid = 1'b0;
      @(negedge clk);  // DECODE
      @(negedge clk);  // EXECUTE
      chk("mid_fs", 32'(bus.FS), 32'(iw[14:12]));
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_ctl", 32'(all_ctl()), 32'd0);
      chk("mid_rst_bus", 32'({bus.imm_out, bus.pc_offset}), 32'd0);
      ill_model = 1'b0;
      @(negedge clk);
      chk("mid_rst_hold", 32'(all_ctl()), 32'd0);
      rst = 1'b0;
      #1;
      chk("mid_rel_ready", 32'(bus.instr_ready), 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("mid_no_pulse", 32'({bus.wr_en, bus.pc_inc, bus.pc_load}), 32'd0);
         chk("mid_restart_ready", 32'(bus.instr_ready), 32'd1);
      end
      $display("reset during EXECUTE of %04h: abandoned", iw);
   endtask

   initial begin
      logic [15:0] iw;
      n_checks        = 0;
      n_bad           = 0;
      ill_model       = 1'b0;
      rst             = 1'b1;
      bus.instr_valid = 1'b0;
      bus.instr       = 16'h0000;
      bus.zero_flag   = 1'b0;

      #3;
      chk("rst_ctl", 32'(all_ctl()), 32'd0);
      chk("rst_bus", 32'({bus.imm_out, bus.pc_offset}), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rel_ready_early", 32'(bus.instr_ready), 32'd0);
      @(negedge clk);
      chk("rel_ready", 32'(bus.instr_ready), 32'd1);
      $display("reset released");

      run_instr(16'h0312, 1'($urandom_range(0, 1)));  // ADD r3 = r1 + r2
      run_instr(16'h95A7, 1'b0);                      // LDI r5, 0xA7
      run_instr(16'hA4FE, 1'b1);                      // BZ taken
      run_instr(16'hA4FE, 1'b0);                      // BZ not taken
      run_instr(16'hB4FE, 1'b1);                      // BNZ not taken
      run_instr(16'hB4FE, 1'b0);                      // BNZ taken
      run_instr(16'hC012, 1'b1);                      // JMP
      run_instr(16'h8730, 1'b0);                      // MOV
      run_instr(16'hD123, 1'b0);                      // illegal
      for (int i = 0; i < 10; i++) begin
         iw = {4'($urandom_range(0, 14)), 12'($urandom)};
         run_instr(iw, 1'($urandom_range(0, 1)));
      end

      reset_mid_execute();

      for (int i = 0; i < 30; i++) begin
         iw = {4'($urandom_range(0, 14)), 12'($urandom)};
         run_instr(iw, 1'($urandom_range(0, 1)));
      end

      run_instr(16'hF000, 1'b0);  // HALT
      bus.instr_valid = 1'b1;
      bus.instr       = 16'h0123;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("halt_halted", 32'(bus.halted), 32'd1);
         chk("halt_ready", 32'(bus.instr_ready), 32'd0);
         chk("halt_pulses", 32'({bus.wr_en, bus.pc_inc, bus.pc_load}), 32'd0);
      end
      bus.instr_valid = 1'b0;
      #2;
      rst = 1'b1;
      #2;
      chk("halt_rst_halted", 32'(bus.halted), 32'd0);
      rst = 1'b0;
      ill_model = 1'b0;
      @(negedge clk);
      chk("halt_exit_halted", 32'(bus.halted), 32'd0);
      chk("halt_exit_ready", 32'(bus.instr_ready), 32'd1);
      $display("halt exited by reset");

      run_instr(16'h1456, 1'b1);  // SUB after restart

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Multi-cycle control sequencer that drives the processor's functional unit from the opposite side of its interface. It accepts 16-bit instructions over a valid/ready handshake and decodes each one. It then issues the function select, A/B pass-through and immediate controls, samples the returned zero flag, and finally commands register-file writeback or PC update. It sits between the instruction source/PC and the datapath (register file and functional unit).

## Interface
- nBit, 16, datapath width; sets the `imm_out` width.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  instruction source has `instr` valid.
- instr  in  16  instruction word {op[15:12], rd[11:8], ra[7:4], rb[3:0]}; imm8/offset8 = instr[7:0].
- instr_ready  out  1  sequencer can accept an instruction.
- zero_flag  in  1  functional-unit zero flag.
- FS  out  3  function select to the functional unit.
- A_thru  out  1  functional unit passes A.
- B_thru  out  1  functional unit passes B.
- a_sel  out  4  register-file read address, A port.
- b_sel  out  4  register-file read address, B port.
- imm_sel  out  1  B bus takes `imm_out` instead of the register file.
- imm_out  out  nBit  zero-extended imm8.
- wr_en  out  1  register-file write strobe.
- wr_addr  out  4  register-file write address.
- pc_inc  out  1  one-cycle pulse: PC += 1.
- pc_load  out  1  one-cycle pulse: PC += sign-extended `pc_offset`.
- pc_offset  out  8  branch/jump offset.
- halted  out  1  HALT executed.
- illegal  out  1  sticky: an illegal opcode was seen.

## Operation
- States: FETCH, DECODE, EXECUTE, COMPLETE, HALT.
- Instruction register IR and zero register z_q are internal.
- All outputs except `instr_ready` decode combinationally from the state and IR only. There is no combinational path from `instr` or `zero_flag` to any output.
- FETCH:
  - `instr_ready` = 1.
  - On `instr_valid & instr_ready`, IR <= instr and the state goes to DECODE.
  - Otherwise the state holds.
- DECODE: a_sel = ra and b_sel = rb (for branches, a_sel = rd). Next state is EXECUTE.
- EXECUTE drives the opcode controls:
  - op 0x0–0x7 (ALU/shift): FS = op[2:0], thru = 0.
  - 0x8 MOV: A_thru = 1.
  - 0x9 LDI: B_thru = 1, imm_sel = 1.
  - 0xA BZ / 0xB BNZ: A_thru = 1, a_sel = rd.
  - 0xC JMP, 0xD/0xE (illegal), 0xF HALT: FS = 0, thru = 0.
- End of EXECUTE: z_q <= zero_flag. Next state is COMPLETE.
- COMPLETE (EXECUTE controls stay held):
  - ops 0x0–0x9: wr_en = 1, wr_addr = rd, pc_inc = 1.
  - BZ: pc_load = 1 if z_q, else pc_inc = 1. BNZ is the inverse.
  - JMP: pc_load = 1.
  - 0xD/0xE: illegal <= 1, pc_inc = 1, no write.
  - HALT: no pulses; next state is HALT.
  - All other ops return to FETCH.
- pc_offset = IR[7:0] for BZ, BNZ and JMP; otherwise 0.
- HALT state: `halted` = 1, `instr_ready` = 0. Only reset exits this state.
- Exactly one of `pc_inc`/`pc_load` pulses per non-HALT instruction. They are never asserted together.

## Timing
- Reset (asynchronous, asserted at any time, including mid-instruction):
  - State goes to FETCH; IR, z_q and illegal are cleared.
  - While rst = 1, every output is 0, `instr_ready` included.
  - Any instruction in progress is abandoned with no wr_en or PC pulse.
- `instr_ready` = 1 from the first clk edge after rst deasserts.
- Latency per instruction is 4 cycles: accept (FETCH), DECODE, EXECUTE, COMPLETE. The wr_en/PC pulse comes 3 cycles after the accept edge.
- Peak throughput is 1 instruction per 4 cycles. `instr_ready` is 0 in DECODE, EXECUTE and COMPLETE.
- `instr_valid` held with `instr_ready` = 0 is ignored. `instr` may change freely outside FETCH.
- zero_flag is sampled only on the edge ending EXECUTE. Changes during COMPLETE have no effect.
- `illegal` sets on the edge ending COMPLETE and stays set until reset.

## Test plan
- Reset, then ADD (op 0x0, rd 3, ra 1, rb 2):
  - FS = 0, thru = 0 in EXECUTE.
  - wr_en = 1 with wr_addr = 3 and pc_inc = 1 exactly 3 cycles after accept.
  - instr_ready returns 1 the next cycle.
- LDI rd 5, imm 0xA7 → imm_out = 16'h00A7, imm_sel = 1, B_thru = 1, wr_addr = 5.
- BZ rd 4, offset 0xFE:
  - with zero_flag = 1 at end of EXECUTE → pc_load = 1, pc_offset = 0xFE, no wr_en.
  - repeat with zero_flag = 0 → pc_inc = 1.
  - repeat as BNZ → inverse outcomes.
- Opcode 0xD → no wr_en, pc_inc = 1, illegal = 1 and still 1 after 10 further instructions.
- HALT:
  - halted = 1, instr_ready = 0 indefinitely with instr_valid = 1.
  - rst pulse → halted = 0, instr_ready = 1.
- Assert rst asynchronously during EXECUTE of an ALU op → outputs 0 immediately, no wr_en ever, clean restart in FETCH.
